// File: rtl/sobel_line_buffer_if.sv
// Pixel-in / column-out bundle for the Sobel line buffer.
// The master modport is the pixel source; the slave modport is the line buffer.
interface sobel_line_buffer_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 10
);
  logic                   frameStart;
  logic                   pixelValid;
  logic [PIXEL_WIDTH-1:0] pixelData;
  logic                   columnValid;
  logic [PIXEL_WIDTH-1:0] columnTop;
  logic [PIXEL_WIDTH-1:0] columnMid;
  logic [PIXEL_WIDTH-1:0] columnBottom;
  logic [X_BITS-1:0]      columnX;
  logic [Y_BITS-1:0]      columnY;
  logic                   lineDone;

  modport master (
    output frameStart, pixelValid, pixelData,
    input  columnValid, columnTop, columnMid, columnBottom, columnX, columnY, lineDone
  );

  modport slave (
    input  frameStart, pixelValid, pixelData,
    output columnValid, columnTop, columnMid, columnBottom, columnX, columnY, lineDone
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-line buffer emitting vertical 3-pixel columns (y-2, y-1, y) one cycle after each pixel.
// Build option SOBEL_BORDER_REPLICATE_EN: emit from row 0, replicating missing rows.
module sobel_line_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_WIDTH  = 640,
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 10
) (
  input logic                clock,
  input logic                reset,
  sobel_line_buffer_if.slave bus
);
  localparam int ADDR_BITS = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(LINE_WIDTH - 1);
  localparam logic [Y_BITS-1:0] Y_MAX  = '1;

  logic [PIXEL_WIDTH-1:0] line_mem0 [LINE_WIDTH];
  logic [PIXEL_WIDTH-1:0] line_mem1 [LINE_WIDTH];

  logic [X_BITS-1:0]      x, x_eff;
  logic [Y_BITS-1:0]      y, y_eff;
  logic [1:0]             rows_filled, rows_eff;
  logic [ADDR_BITS-1:0]   addr;
  logic [PIXEL_WIDTH-1:0] rd0, rd1, top, mid;
  logic                   emit;

  // frameStart wins over a coincident pixel, so the pixel sees a fresh frame.
  always_comb begin
    x_eff    = bus.frameStart ? '0 : x;
    y_eff    = bus.frameStart ? '0 : y;
    rows_eff = bus.frameStart ? 2'd0 : rows_filled;
    addr     = x_eff[ADDR_BITS-1:0];
    rd0      = line_mem0[addr];
    rd1      = line_mem1[addr];
`ifdef SOBEL_BORDER_REPLICATE_EN
    emit = 1'b1;
    case (rows_eff)
      2'd0: begin top = bus.pixelData; mid = bus.pixelData; end
      2'd1: begin top = rd0;           mid = rd0;           end
      default: begin top = rd1;        mid = rd0;           end
    endcase
`else
    emit = (rows_eff == 2'd2);
    top  = rd1;
    mid  = rd0;
`endif
  end

  // Unreset storage; reads above see the pre-write contents.
  always_ff @(posedge clock) begin
    if (bus.pixelValid) begin
      line_mem1[addr] <= rd0;
      line_mem0[addr] <= bus.pixelData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x                <= '0;
      y                <= '0;
      rows_filled      <= 2'd0;
      bus.columnValid  <= 1'b0;
      bus.lineDone     <= 1'b0;
      bus.columnTop    <= '0;
      bus.columnMid    <= '0;
      bus.columnBottom <= '0;
      bus.columnX      <= '0;
      bus.columnY      <= '0;
    end else begin
      bus.columnValid <= 1'b0;
      bus.lineDone    <= 1'b0;
      if (bus.frameStart) begin
        x           <= '0;
        y           <= '0;
        rows_filled <= 2'd0;
      end
      if (bus.pixelValid) begin
        if (x_eff == X_LAST) begin
          x           <= '0;
          y           <= (y_eff == Y_MAX) ? y_eff : y_eff + 1'b1;
          rows_filled <= (rows_eff == 2'd2) ? 2'd2 : rows_eff + 2'd1;
        end else begin
          x           <= x_eff + 1'b1;
          y           <= y_eff;
          rows_filled <= rows_eff;
        end
        if (emit) begin
          bus.columnValid  <= 1'b1;
          bus.lineDone     <= (x_eff == X_LAST);
          bus.columnTop    <= top;
          bus.columnMid    <= mid;
          bus.columnBottom <= bus.pixelData;
          bus.columnX      <= x_eff;
          bus.columnY      <= y_eff;
        end
      end
    end
  end
endmodule

// File: tb/tb_sobel_line_buffer.sv
// Directed bench for sobel_line_buffer with a 4-pixel line; expectations from pixel = off + 16*y + x.
// Honours SOBEL_BORDER_REPLICATE_EN when the build defines it.
module tb_sobel_line_buffer;
  localparam int PW = 8;
  localparam int LW = 4;
  localparam int XB = 2;
  localparam int YB = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sobel_line_buffer_if #(.PIXEL_WIDTH(PW), .X_BITS(XB), .Y_BITS(YB)) bus ();

  sobel_line_buffer #(.PIXEL_WIDTH(PW), .LINE_WIDTH(LW), .X_BITS(XB), .Y_BITS(YB)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int x;
    int y;
    int data;
    bit fs;
    bit exp_valid;
    int exp_top;
    int exp_mid;
    int exp_bot;
    bit exp_ld;
  } vec_t;

`ifdef SOBEL_BORDER_REPLICATE_EN
  localparam int COLS_PER_FRAME = 16;
  localparam int LD_PER_FRAME   = 4;
`else
  localparam int COLS_PER_FRAME = 8;
  localparam int LD_PER_FRAME   = 2;
`endif

  int errors = 0;
  int checks = 0;
  int cols   = 0;
  int lds    = 0;
  vec_t table_a [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t make_vec(input int off, input int x, input int y, input bit fs);
    vec_t v;
    v.x    = x;
    v.y    = y;
    v.data = (off + 16 * y + x) & 8'hff;
    v.fs   = fs;
    v.exp_bot = v.data;
`ifdef SOBEL_BORDER_REPLICATE_EN
    v.exp_valid = 1'b1;
    if (y == 0) begin
      v.exp_top = v.data;
      v.exp_mid = v.data;
    end else if (y == 1) begin
      v.exp_top = (off + x) & 8'hff;
      v.exp_mid = (off + x) & 8'hff;
    end else begin
      v.exp_top = (off + 16 * (y - 2) + x) & 8'hff;
      v.exp_mid = (off + 16 * (y - 1) + x) & 8'hff;
    end
`else
    v.exp_valid = (y >= 2);
    v.exp_top   = (off + 16 * (y - 2) + x) & 8'hff;
    v.exp_mid   = (off + 16 * (y - 1) + x) & 8'hff;
`endif
    v.exp_ld = v.exp_valid && (x == LW - 1);
    return v;
  endfunction

  // Drive one pixel now, check its column one edge later.
  task automatic apply_check(input vec_t v);
    bus.pixelValid = 1'b1;
    bus.pixelData  = PW'(v.data);
    bus.frameStart = v.fs;
    @(posedge clock);
    #1;
    bus.frameStart = 1'b0;
    bus.pixelValid = 1'b0;
    if (bus.columnValid) cols++;
    if (bus.lineDone) lds++;
    check($sformatf("valid(%0d,%0d)", v.x, v.y), 32'(bus.columnValid), 32'(v.exp_valid));
    check($sformatf("line_done(%0d,%0d)", v.x, v.y), 32'(bus.lineDone), 32'(v.exp_ld));
    if (v.exp_valid) begin
      check($sformatf("top(%0d,%0d)", v.x, v.y), 32'(bus.columnTop), 32'(v.exp_top));
      check($sformatf("mid(%0d,%0d)", v.x, v.y), 32'(bus.columnMid), 32'(v.exp_mid));
      check($sformatf("bot(%0d,%0d)", v.x, v.y), 32'(bus.columnBottom), 32'(v.exp_bot));
      check($sformatf("col_x(%0d,%0d)", v.x, v.y), 32'(bus.columnX), 32'(v.x));
      check($sformatf("col_y(%0d,%0d)", v.x, v.y), 32'(bus.columnY), 32'(v.y));
    end
  endtask

  task automatic run_frame(input int off, input bit fs, input int max_gap, input int npix);
    vec_t v;
    int   g;
    for (int i = 0; i < npix; i++) begin
      v = make_vec(off, i % LW, i / LW, fs && (i == 0));
      apply_check(v);
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int k = 0; k < g; k++) begin
        @(posedge clock);
        #1;
        check("gap_valid", 32'(bus.columnValid), 32'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) table_a[i] = make_vec(0, i % LW, i / LW, 1'b0);

    bus.frameStart = 1'b0;
    bus.pixelValid = 1'b0;
    bus.pixelData  = '0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 32'(bus.columnValid), 32'd0);
    check("rst_line_done", 32'(bus.lineDone), 32'd0);
    check("rst_top", 32'(bus.columnTop), 32'd0);
    check("rst_mid", 32'(bus.columnMid), 32'd0);
    check("rst_bot", 32'(bus.columnBottom), 32'd0);
    check("rst_x", 32'(bus.columnX), 32'd0);
    check("rst_y", 32'(bus.columnY), 32'd0);
    reset = 1'b0;

    // Frame A: back-to-back pixels, no frameStart after reset.
    cols = 0; lds = 0;
    for (int i = 0; i < 16; i++) apply_check(table_a[i]);
    check("frame_a_columns", 32'(cols), 32'(COLS_PER_FRAME));
    check("frame_a_line_done", 32'(lds), 32'(LD_PER_FRAME));

    // Extra row without frameStart: y saturates at 3, data keeps flowing.
    for (int x = 0; x < LW; x++) begin
      vec_t v;
      v.x = x; v.y = 3; v.data = 8'h40 + x; v.fs = 1'b0;
      v.exp_valid = 1'b1; v.exp_top = 8'h20 + x; v.exp_mid = 8'h30 + x;
      v.exp_bot = 8'h40 + x; v.exp_ld = (x == LW - 1);
      apply_check(v);
    end

    // Frame B: same image with random gaps, frameStart coincident with first pixel.
    cols = 0; lds = 0;
    run_frame(0, 1'b1, 5, 16);
    check("frame_b_columns", 32'(cols), 32'(COLS_PER_FRAME));
    check("frame_b_line_done", 32'(lds), 32'(LD_PER_FRAME));

    // Frame C aborted after (2,2); frame D must use only its own data.
    run_frame(0, 1'b1, 2, 11);
    cols = 0; lds = 0;
    run_frame(8'h80, 1'b1, 1, 16);
    check("frame_d_columns", 32'(cols), 32'(COLS_PER_FRAME));
    check("frame_d_line_done", 32'(lds), 32'(LD_PER_FRAME));

    // Reset between edges while a column is being presented.
    run_frame(0, 1'b1, 0, 9);
    check("pre_reset_valid", 32'(bus.columnValid), 32'd1);
    bus.pixelValid = 1'b1;
    bus.pixelData  = 8'h21;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(bus.columnValid), 32'd0);
    check("async_reset_bot", 32'(bus.columnBottom), 32'd0);
    bus.pixelValid = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    cols = 0; lds = 0;
    for (int i = 0; i < 16; i++) apply_check(table_a[i]);
    check("post_reset_columns", 32'(cols), 32'(COLS_PER_FRAME));
    check("post_reset_line_done", 32'(lds), 32'(LD_PER_FRAME));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_line_buffer.md
# sobel_line_buffer

Parametrised single-clock line buffer for the camera Sobel path. It accepts a raster pixel stream and emits one vertical 3-pixel column per accepted pixel: rows y-2, y-1 and y at the same x. Two internal line memories replace the fixed 256x16 dual-clock buffer of the previous generation. It sits between the camera pixel pipeline and the 3x3 Sobel kernel, which forms the horizontal window itself.

## Interface
Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- LINE_WIDTH, 640, pixels per line; must be at least 4.
- X_BITS, 10, width of the x counter; must satisfy 2^X_BITS >= LINE_WIDTH.
- Y_BITS, 10, width of the y counter.

Ports:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- frameStart  input  1  one-cycle pulse; restarts x/y at 0 and invalidates buffered lines.
- pixelValid  input  1  pixelData is accepted this cycle. There is no back-pressure.
- pixelData  input  PIXEL_WIDTH  incoming pixel, raster order.
- columnValid  output  1  column outputs are valid this cycle (one-cycle pulse per column).
- columnTop  output  PIXEL_WIDTH  pixel at (x, y-2).
- columnMid  output  PIXEL_WIDTH  pixel at (x, y-1).
- columnBottom  output  PIXEL_WIDTH  pixel at (x, y); this is the incoming pixel.
- columnX  output  X_BITS  x of the emitted column.
- columnY  output  Y_BITS  y of the emitted column (bottom row).
- lineDone  output  1  one-cycle pulse together with the column at x = LINE_WIDTH-1.

## Operation
- x and y counters are both reset to 0.
- Each accepted pixel (pixelValid=1) advances x.
  - At x = LINE_WIDTH-1, x wraps to 0 and y increments.
  - y saturates at 2^Y_BITS-1.
- Line memories:
  - lineMem0 holds row y-1.
  - lineMem1 holds row y-2.
  - Both have LINE_WIDTH words of PIXEL_WIDTH bits.
  - For each accepted pixel at x: the old lineMem1[x] goes to top, the old lineMem0[x] goes to mid and to lineMem1[x], and pixelData goes to lineMem0[x].
  - Read-old-data semantics are mandatory.
  - Memory contents are not reset.
- rowsFilled counter (0..2) tracks how many valid rows are buffered:
  - It increments on each line wrap and saturates at 2.
  - frameStart and reset clear it.
- Emission rule (default build): columnValid fires only for pixels with rowsFilled = 2, i.e. y >= 2.
- frameStart and pixelValid in the same cycle: frameStart takes effect first, so the pixel is treated as x=0, y=0.
- pixelValid may drop for any number of cycles, including mid-line. Gaps insert no columns, and counters hold.
- Lines shorter than LINE_WIDTH are not supported; only frameStart resynchronises.
- Reset mid-line or mid-frame: all counters go to 0 immediately, and any in-flight column is dropped.

## Timing
- Latency is exactly 1 cycle: a pixel accepted in cycle n gives columnValid, the column data, columnX/columnY and lineDone in cycle n+1.
- Throughput is one pixel per clock, sustained.
- Outputs are registered. When columnValid=0, column data holds its last value and checkers must ignore it.
- Reset values:
  - columnValid = 0, lineDone = 0.
  - columnTop/Mid/Bottom = 0.
  - columnX = 0, columnY = 0.
- frameStart asserted in cycle n: a column from a pixel accepted in cycle n-1 still emits in cycle n. Pixels from cycle n onward belong to the new frame.

## Configuration
- Macro: SOBEL_BORDER_REPLICATE_EN.
- Defined: columns are emitted from row 0, with missing rows replaced by replication.
  - rowsFilled = 0: top = mid = bottom = pixelData.
  - rowsFilled = 1: top = mid = lineMem0[x].
  - columnValid fires for every accepted pixel. Output frame size equals input frame size.
- Undefined: the emission rule above applies, and the first two rows of each frame produce no columns.
- Latency and interface are identical in both builds.

## Test plan
- Reset, then a 4x4 frame with LINE_WIDTH=4 and pixel = 16*y+x, at one pixel per clock:
  - Default build: 8 columns, for y=2 and y=3 only.
  - Column (x=1, y=2) = top 0x01, mid 0x11, bottom 0x21, valid 1 cycle after the pixel.
- Same frame with random pixelValid gaps (0-5 cycles): identical column sequence, one column per accepted pixel, columnX/columnY continuous.
- Second frame with frameStart mid-frame (after x=2, y=2):
  - No column emitted until the new frame reaches y=2.
  - The first new column at (0,2) uses only new-frame data.
- frameStart coincident with pixelValid: that pixel is reported as x=0, y=0, and the column output for (0,2) is computed from it.
- Async reset asserted mid-line between clock edges:
  - columnValid drops to 0 without waiting for a clock edge.
  - After release, a new frame behaves as in the first scenario.
- SOBEL_BORDER_REPLICATE_EN build, same 4x4 frame:
  - 16 columns are emitted.
  - Column (x=3, y=0) = 0x03/0x03/0x03.
  - Column (x=3, y=1) = 0x03/0x03/0x13.
  - lineDone pulses 4 times.
